// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, NOP word and the
// instruction field bit positions that the decode stage also relies on.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int F3_W    = 3;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  localparam int F7_W    = 7;
  localparam int REG_W   = 5;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel (one outstanding request).
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load / hold / flush control plus field slicing.
// The misalign flag exists only when FETCH_MISALIGN_TRAP_EN is defined.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
`ifdef FETCH_MISALIGN_TRAP_EN
  input  logic             misalign_i,
  output logic             misalign_o,
`endif
  output logic             valid_o,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc4_o,
  output logic [OPC_W-1:0] opcode_o,
  output logic [F3_W-1:0]  funct3_o,
  output logic [F7_W-1:0]  funct7_o,
  output logic [REG_W-1:0] rd_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o
);

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4_q;

  // Load wins over flush so a redirect can deposit a trap record.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + XLEN'(4);
    end else if (flush_i || !stall_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst)         misalign_q <= 1'b0;
    else if (load_i) misalign_q <= misalign_i;
  end

  assign misalign_o = misalign_q;
`endif

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign pc4_o    = pc4_q;
  assign opcode_o = instr_q[OPC_LSB +: OPC_W];
  assign funct3_o = instr_q[F3_LSB  +: F3_W];
  assign funct7_o = instr_q[F7_LSB  +: F7_W];
  assign rd_o     = instr_q[RD_LSB  +: REG_W];
  assign rs1_o    = instr_q[RS1_LSB +: REG_W];
  assign rs2_o    = instr_q[RS2_LSB +: REG_W];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry hold buffer and IF/ID.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_if.master          imem,
  input  logic             id_stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic             id_misalign,
`endif
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc4,
  output logic [6:0]       id_opcode,
  output logic [2:0]       id_funct3,
  output logic [6:0]       id_funct7,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     hold_q, hold_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            halt_q, halt_d;

  logic            accept, outstanding;
  logic            ld, flush;
  logic [31:0]     ld_instr;
  logic [XLEN-1:0] ld_pc;
  logic [XLEN-1:0] redir_pc;

  assign imem.imem_req_valid = (state_q == REQ);
  assign imem.imem_addr      = pc_q;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  // A response is still owed after this edge unless it is arriving right now.
  assign outstanding = ((state_q == WAIT || state_q == DRAIN) && !imem.imem_rsp_valid)
                     || accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic ld_mis;
  logic redir_mis;
  assign redir_pc  = redirect_pc;
  assign redir_mis = |redirect_pc[1:0];
`else
  assign redir_pc  = redirect_pc & ~XLEN'(3);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      hold_q    <= NOP_INSTR;
      hold_pc_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    halt_d    = halt_q;
    ld        = 1'b0;
    flush     = 1'b0;
    ld_instr  = imem.imem_rsp_data;
    ld_pc     = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    ld_mis    = 1'b0;
`endif

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (accept) state_d = WAIT;
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          pc_d = pc_q + XLEN'(4);
          if (id_stall) begin
            hold_d    = imem.imem_rsp_data;
            hold_pc_d = pc_q;
            state_d   = HOLD;
          end else begin
            ld      = 1'b1;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!halt_q && !id_stall) begin
          ld       = 1'b1;
          ld_instr = hold_q;
          ld_pc    = hold_pc_q;
          state_d  = REQ;
        end
      end
      DRAIN: if (imem.imem_rsp_valid) state_d = halt_q ? HOLD : REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides stall and discards whatever the FSM decided above.
    if (redirect_valid) begin
      ld      = 1'b0;
      flush   = 1'b1;
      pc_d    = redir_pc;
      halt_d  = 1'b0;
      state_d = outstanding ? DRAIN : REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir_mis) begin
        ld       = 1'b1;
        ld_instr = NOP_INSTR;
        ld_pc    = redirect_pc;
        ld_mis   = 1'b1;
        halt_d   = 1'b1;
        if (!outstanding) state_d = HOLD;
      end
`endif
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .flush_i    (flush),
    .stall_i    (id_stall),
    .instr_i    (ld_instr),
    .pc_i       (ld_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_i (ld_mis),
    .misalign_o (id_misalign),
`endif
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc4_o      (id_pc4),
    .opcode_o   (id_opcode),
    .funct3_o   (id_funct3),
    .funct7_o   (id_funct7),
    .rd_o       (id_rd),
    .rs1_o      (id_rs1),
    .rs2_o      (id_rs2)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a program-order reference model and memory responder.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rd, id_rs1, id_rs2;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  fetch_if #(.XLEN(XLEN)) imem ();

  fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem.master),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .id_misalign    (id_misalign),
`endif
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7),
    .id_rd          (id_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0008: return 32'h4020_8033;
      32'h0000_000C: return 32'hDEAD_BEEF;
      default:       return (a * 32'd2654435761) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return a & ~32'd3;
`endif
  endfunction

  // Memory: fixed latency `lat` cycles after acceptance; response held over one rising edge.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  always @(negedge clk) begin
    imem.imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt <= 1) begin
          imem.imem_rsp_valid = 1'b1;
          imem.imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = imem.imem_addr;
      end
    end
  end

  // Reference model: IF/ID shows program order, each word until decode takes it;
  // fetch addresses are sequential from the last redirect.
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] fetch_exp = 32'h0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      exp_pc    = 32'h0;
      fetch_exp = 32'h0;
    end else begin
      if (id_valid) begin
        w = (exp_pc[1:0] != 2'b00) ? NOP_INSTR : mem_word(exp_pc);
        chk("m_id_pc",     id_pc,     exp_pc);
        chk("m_id_pc4",    id_pc4,    exp_pc + 32'd4);
        chk("m_id_instr",  id_instr,  w);
        chk("m_id_opcode", {25'd0, id_opcode}, {25'd0, w[6:0]});
        chk("m_id_rd",     {27'd0, id_rd},     {27'd0, w[11:7]});
        chk("m_id_funct3", {29'd0, id_funct3}, {29'd0, w[14:12]});
        chk("m_id_rs1",    {27'd0, id_rs1},    {27'd0, w[19:15]});
        chk("m_id_rs2",    {27'd0, id_rs2},    {27'd0, w[24:20]});
        chk("m_id_funct7", {25'd0, id_funct7}, {25'd0, w[31:25]});
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("m_id_misalign", {31'd0, id_misalign}, {31'd0, exp_pc[1:0] != 2'b00});
`endif
      end
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        chk("m_imem_addr", imem.imem_addr, fetch_exp);
        fetch_exp = fetch_exp + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc    = align(redirect_pc);
        fetch_exp = align(redirect_pc);
      end else if (id_valid && !id_stall) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int nv;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;

    step(3);
    chk("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    chk("rst_id_valid",  {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr",  id_instr, 32'h0000_0013);
    chk("rst_id_pc",     id_pc,  32'h0);
    chk("rst_id_pc4",    id_pc4, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_id_misalign", {31'd0, id_misalign}, 32'd0);
`endif
    rst = 1'b0;

    // First fetch
    chk("idle_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
    step(1);
    chk("first_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    chk("first_req_addr",  imem.imem_addr, 32'h0);
    step(2);
    chk("first_id_valid",  {31'd0, id_valid}, 32'd1);
    chk("first_id_pc",     id_pc, 32'h0);
    chk("first_id_opcode", {25'd0, id_opcode}, 32'h13);
    chk("first_id_rd",     {27'd0, id_rd}, 32'd1);
    chk("second_req_addr", imem.imem_addr, 32'h4);

    // Stall while 0x40208033 returns
    step(2);
    id_stall = 1'b1;
    step(2);
    chk("hold_no_req_a", {31'd0, imem.imem_req_valid}, 32'd0);
    step(1);
    chk("hold_no_req_b", {31'd0, imem.imem_req_valid}, 32'd0);
    chk("hold_id_pc",    id_pc, 32'h4);
    id_stall = 1'b0;
    step(1);
    chk("unhold_id_valid",  {31'd0, id_valid}, 32'd1);
    chk("unhold_id_pc",     id_pc, 32'h8);
    chk("unhold_id_funct7", {25'd0, id_funct7}, 32'h20);
    chk("unhold_id_funct3", {29'd0, id_funct3}, 32'h0);
    chk("unhold_req_addr",  imem.imem_addr, 32'hC);

    // Redirect in WAIT, stale 0xDEADBEEF arrives in DRAIN
    lat = 2;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    chk("drain_no_req",   {31'd0, imem.imem_req_valid}, 32'd0);
    chk("drain_id_valid", {31'd0, id_valid}, 32'd0);
    step(1);
    chk("redir_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    chk("redir_req_addr",  imem.imem_addr, 32'h100);
    lat = 1;
    step(2);
    chk("redir_id_pc", id_pc, 32'h100);

    // Back-pressure: request must stay stable
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
      chk("bp_req_addr",  imem.imem_addr, 32'h104);
      step(1);
    end
    imem.imem_req_ready = 1'b1;
    chk("bp_req_addr_end", imem.imem_addr, 32'h104);

    // Redirect to top of address space, same cycle as a response (no DRAIN)
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    chk("wrap_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    chk("wrap_req_addr",  imem.imem_addr, 32'hFFFF_FFFC);
    t = 0;
    while (!(id_valid && id_pc == 32'hFFFF_FFFC) && t < 20) begin step(1); t++; end
    chk("wrap_wait_id", {31'd0, t < 20}, 32'd1);
    chk("wrap_id_pc4",  id_pc4, 32'h0);
    t = 0;
    while (!(imem.imem_req_valid && imem.imem_addr != 32'hFFFF_FFFC) && t < 20) begin step(1); t++; end
    chk("wrap_wait_req", {31'd0, t < 20}, 32'd1);
    chk("wrap_next_addr", imem.imem_addr, 32'h0);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step(1);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_id_valid",    {31'd0, id_valid}, 32'd1);
    chk("mis_id_misalign", {31'd0, id_misalign}, 32'd1);
    chk("mis_id_instr",    id_instr, 32'h0000_0013);
    chk("mis_id_pc",       id_pc, 32'h102);
    for (int i = 0; i < 6; i++) begin
      chk("mis_halt_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
      step(1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    t = 0;
    while (!imem.imem_req_valid && t < 20) begin step(1); t++; end
    chk("mis_wait_req", {31'd0, t < 20}, 32'd1);
    chk("mis_resume_addr", imem.imem_addr, 32'h200);
`else
    t = 0;
    while (!imem.imem_req_valid && t < 20) begin step(1); t++; end
    chk("align_wait_req", {31'd0, t < 20}, 32'd1);
    chk("align_req_addr", imem.imem_addr, 32'h100);
`endif

    // Zero-wait throughput: one instruction every 2 cycles
    t = 0;
    while (!id_valid && t < 20) begin step(1); t++; end
    chk("tp_wait_id", {31'd0, t < 20}, 32'd1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (id_valid) nv++;
      step(1);
    end
    chk("tp_count", nv, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage plus IF/ID pipeline register. Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with one outstanding request. It buffers the returned instruction and presents it, pre-split into opcode/funct3/funct7/register fields, to the decode stage that generates RUWr, IMMSrc, ALUop and the other control signals. It honours decode stalls and execute-stage redirects (branch/jump flush).

## Interface
- XLEN, 32, PC and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  word address of request, bits [1:0] always 0
- imem_rsp_valid  in  1  instruction word returned, exactly once per accepted request
- imem_rsp_data  in  32  instruction word
- id_stall  in  1  decode cannot accept a new instruction; IF/ID holds
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  instruction word
- id_pc, id_pc4  out  XLEN  instruction address and address+4
- id_opcode  out  7  id_instr[6:0]
- id_funct3  out  3  id_instr[14:12]
- id_funct7  out  7  id_instr[31:25]
- id_rd, id_rs1, id_rs2  out  5 each  id_instr[11:7], [19:15], [24:20]
- id_misalign  out  1  present only with FETCH_MISALIGN_TRAP_EN

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: entered on reset; moves to REQ the next cycle.
- REQ: imem_req_valid=1, imem_addr=pc. Moves to WAIT on valid&ready. The request stays stable until accepted.
- WAIT: awaits imem_rsp_valid. On response with id_stall=0, load IF/ID (instr, pc, pc+4, id_valid=1), pc<=pc+4, go to REQ. With id_stall=1, store the word in a one-entry hold buffer, pc<=pc+4, go to HOLD.
- HOLD: no request is issued. When id_stall falls, move the hold buffer to IF/ID and go to REQ.
- IF/ID with id_stall=1: all id_* outputs keep their values. With id_stall=0 and no new word loaded, id_valid<=0 (bubble).
- Redirect: redirect_valid=1 overrides id_stall.
  - On that edge: id_valid<=0, hold buffer invalidated, pc<=redirect_pc.
  - Request accepted and response not yet returned (WAIT, or REQ accepted on the same edge): go to DRAIN, discard the next response, then go to REQ.
  - Otherwise: go to REQ.
- pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
- Field outputs are pure slices of id_instr. They are never decoded here.

## Timing
- During rst: pc=RESET_PC, state=IDLE, imem_req_valid=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc4=0, id_misalign=0. Hold buffer is empty and any in-flight response is forgotten.
- First request: asserted 2 cycles after rst falls (IDLE, then REQ).
- Zero-wait memory (ready=1, response 1 cycle after acceptance): id_valid rises on the edge of the response cycle. Throughput is one instruction per 2 cycles (single outstanding request).
- rst mid-transaction: a response arriving after rst falls but before the first new request is accepted is ignored.
- Redirect and response in the same cycle: the response is discarded and no DRAIN is entered.
- Redirect during DRAIN: pc updates and state stays DRAIN.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect_pc with [1:0]!=0 loads IF/ID with id_valid=1, id_misalign=1, id_instr=NOP and id_pc=redirect_pc.
  - Fetching then halts in HOLD until the next redirect.
- Undefined: redirect_pc[1:0] is forced to 0, and the id_misalign port and logic are absent.

## Structure
- Package fetch_pkg holds:
  - the state enum fetch_state_t;
  - NOP_INSTR=32'h0000_0013;
  - field bit-position localparams shared with the decode stage.
- Sub-module if_id_reg: the IF/ID register with load/hold/flush controls and field slicing. fetch_stage owns the PC, the FSM and the hold buffer.

## Test plan
- Reset release, ready=1, 1-cycle memory returning 0x00500093 -> first imem_addr=0x0; id_valid=1, id_pc=0x0, id_opcode=0x13, id_rd=1 on the edge of the response cycle; next imem_addr=0x4.
- id_stall=1 for 3 cycles while word 0x40208033 returns -> IF/ID unchanged, the word sits in the hold buffer; after stall falls, id_funct7=0x20, id_funct3=0; no extra request issued during HOLD.
- Redirect to 0x100 while in WAIT, stale response 0xDEADBEEF returns next cycle -> 0xDEADBEEF never reaches IF/ID; next request has addr 0x100.
- imem_req_ready low for 4 cycles -> imem_addr stays stable and imem_req_valid stays high throughout.
- Redirect to 0xFFFF_FFFC -> id_pc4=0x0 and the following fetch address is 0x0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> id_misalign=1, id_instr=0x13, no further requests until a redirect to 0x200.
